// File: rtl/e1_led_drv.sv
// e1_led_drv
// ----------
// Serial driver for the four E1 port status LEDs. Once per frame it expands
// four 2-bit LED codes (off / on / slow blink / fast blink) into pin levels
// and shifts them, LED3 first, into an external 74HC595-style shift/latch
// register. The register then gets a single latch pulse. A free-running
// 8-bit blink counter advances once per frame. Bit 5 of that counter
// drives the slow blink (64-frame period) and bit 3 drives the fast blink
// (16-frame period).
//
// Parameters:
//   CLK_DIV       clk cycles per half serial bit (>= 1)
//   FRAME_CYCLES  clk cycles between frame starts (>= 9*CLK_DIV+2)
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   led_state   in   [7:0] LED codes, LED k = bits [2k+1:2k]
//   led_run     in   enable frame generation
//   led_active  out  high while a frame is loaded, shifted or latched
//   led_sclk    out  shift clock, data valid on its rising edge
//   led_sdata   out  serial data
//   led_latch   out  storage-register latch pulse, active high
//
// Optional feature (macro E1_LED_BLANK_EN): when the driver stops, it sends
// one extra all-dark frame before going idle. The blink counter does not
// advance for that frame, and the LEDs end up dark after a stop.

module e1_led_drv #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] led_state,
  input  logic       led_run,
  output logic       led_active,
  output logic       led_sclk,
  output logic       led_sdata,
  output logic       led_latch
);

  localparam int TW = $clog2(FRAME_CYCLES);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GAP
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] frame_timer;
  logic [DW-1:0] div_cnt;
  logic [7:0]    blink_cnt;
  logic [1:0]    bit_idx, bit_idx_next;
  logic [3:0]    pins, pins_load, pins_eff;
  logic          blank_frame, blank_next;
  logic          phase_done, frame_end;

  assign phase_done = (div_cnt == DW'(CLK_DIV - 1));
  assign frame_end  = (state == GAP) && (frame_timer == TW'(FRAME_CYCLES - 1));

  // Pin levels for the frame being loaded, computed from the codes present
  // during LOAD. A blanking frame forces every pin dark.
  always_comb begin
    pins_load = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      case (led_state[2*k +: 2])
        2'b01:   pins_load[k] = 1'b1;
        2'b10:   pins_load[k] = blink_cnt[5];
        2'b11:   pins_load[k] = blink_cnt[3];
        default: pins_load[k] = 1'b0;
      endcase
    end
    if (blank_frame) pins_load = 4'b0000;
  end

  // The first data bit is launched on the same edge that captures the
  // snapshot. That is why the freshly computed pins bypass the register
  // during LOAD.
  assign pins_eff = (state == LOAD) ? pins_load : pins;

  // Next-state logic. Once a frame has started it always runs to the end
  // of GAP, so a shift is never truncated when led_run falls.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    blank_next   = blank_frame;
    case (state)
      IDLE: begin
        if (led_run) begin
          state_next = LOAD;
          blank_next = 1'b0;
        end
      end
      LOAD: begin
        state_next   = SHIFT_LO;
        bit_idx_next = 2'd3;
      end
      SHIFT_LO: begin
        if (phase_done) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_done) begin
          if (bit_idx != 2'd0) begin
            bit_idx_next = bit_idx - 2'd1;
            state_next   = SHIFT_LO;
          end else begin
            state_next = LATCH;
          end
        end
      end
      LATCH: begin
        if (phase_done) state_next = GAP;
      end
      GAP: begin
        if (frame_end) begin
          if (led_run) begin
            state_next = LOAD;
            blank_next = 1'b0;
          end
`ifdef E1_LED_BLANK_EN
          else if (!blank_frame) begin
            state_next = LOAD;
            blank_next = 1'b1;
          end
`endif
          else begin
            state_next = IDLE;
            blank_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters and outputs. The outputs are decoded from the next
  // state and registered, so they line up with the state they describe and
  // have no combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_idx     <= 2'd0;
      blank_frame <= 1'b0;
      div_cnt     <= '0;
      frame_timer <= '0;
      blink_cnt   <= 8'd0;
      pins        <= 4'b0000;
      led_active  <= 1'b0;
      led_sclk    <= 1'b0;
      led_sdata   <= 1'b0;
      led_latch   <= 1'b0;
    end else begin
      state       <= state_next;
      bit_idx     <= bit_idx_next;
      blank_frame <= blank_next;
      div_cnt     <= (state_next != state) ? '0 : div_cnt + 1'b1;

      if (state_next == LOAD)
        frame_timer <= '0;
      else if (state == IDLE)
        frame_timer <= '0;
      else
        frame_timer <= frame_timer + 1'b1;

      if (state == LOAD) begin
        pins <= pins_load;
        if (!blank_frame) blink_cnt <= blink_cnt + 8'd1;
      end

      led_active <= (state_next == LOAD) || (state_next == SHIFT_LO) ||
                    (state_next == SHIFT_HI) || (state_next == LATCH);
      led_sclk   <= (state_next == SHIFT_HI);
      led_latch  <= (state_next == LATCH);
      led_sdata  <= ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ?
                    pins_eff[bit_idx_next] : 1'b0;
    end
  end

endmodule

// File: tb/tb_e1_led_drv.sv
// tb_e1_led_drv
// -------------
// Bench for e1_led_drv with CLK_DIV=2 and FRAME_CYCLES=64. Each frame is
// captured from the pins by watching led_sclk rises, led_latch and
// led_active. The captured frame is compared with a reference that derives
// the expected pin bits from the LED codes and the frame number, using
// plain arithmetic on the blink periods.

module tb_e1_led_drv;

  localparam int CLK_DIV      = 2;
  localparam int FRAME_CYCLES = 64;
  localparam int ACTIVE_LEN   = 1 + 9 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] led_state;
  logic       led_run;
  logic       led_active, led_sclk, led_sdata, led_latch;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [3:0] cap_bits;
  int         cap_act, cap_latch, cap_first, cap_load, cap_glitch;
  bit         cap_ok;
  int         idle_act, idle_sclk;
  int         nf;
  int         last_load;
  logic [7:0] cur_state, new_state;

  e1_led_drv #(
    .CLK_DIV      (CLK_DIV),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_state  (led_state),
    .led_run    (led_run),
    .led_active (led_active),
    .led_sclk   (led_sclk),
    .led_sdata  (led_sdata),
    .led_latch  (led_latch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected pin levels for frame number n: slow blink has a 64-frame
  // period and fast blink a 16-frame period, both dark in the first half.
  function automatic logic [3:0] expBits(input logic [7:0] st, input int n);
    logic [3:0] r;
    int         ph;
    ph = n % 256;
    for (int k = 0; k < 4; k++) begin
      case (st[2*k +: 2])
        2'b00:   r[k] = 1'b0;
        2'b01:   r[k] = 1'b1;
        2'b10:   r[k] = ((ph / 32) % 2) == 1;
        default: r[k] = ((ph / 8) % 2) == 1;
      endcase
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [7:0] st, input logic run);
    led_state = st;
    led_run   = run;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for a frame to start, then records it until led_active
  // drops. The mid_en option changes led_state during SHIFT_HI of bit 2.
  // The drop_en option lowers led_run during SHIFT_LO of bit 2.
  task automatic captureFrame(input bit mid_en, input logic [7:0] mid_val,
                              input bit drop_en);
    int   guard;
    int   nbits;
    logic prev_sclk, prev_sdata;
    guard = 0; nbits = 0;
    cap_bits = 4'b0; cap_act = 0; cap_latch = 0; cap_first = -1;
    cap_glitch = 0; cap_ok = 1'b0; cap_load = -1;
    while (!led_active && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!led_active) return;
    cap_load   = cyc;
    prev_sclk  = 1'b0;
    prev_sdata = led_sdata;
    while (led_active && guard < 400) begin
      if (led_sclk && !prev_sclk) begin
        cap_bits = {cap_bits[2:0], led_sdata};
        nbits++;
        if (cap_first < 0) cap_first = cap_act;
      end
      if (led_sclk && prev_sclk && (led_sdata !== prev_sdata)) cap_glitch++;
      if (led_latch) cap_latch++;
      if (mid_en && nbits == 2 && led_sclk) led_state = mid_val;
      if (drop_en && nbits == 1 && !led_sclk) led_run = 1'b0;
      prev_sclk  = led_sclk;
      prev_sdata = led_sdata;
      cap_act++;
      @(negedge clk);
      guard++;
    end
    cap_ok = !led_active && (nbits == 4);
  endtask

  task automatic watchIdle(input int n);
    idle_act = 0; idle_sclk = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (led_active) idle_act++;
      if (led_sclk)   idle_sclk++;
    end
  endtask

  // Checks one captured frame against the reference for frame number n.
  task automatic checkFrame(input string tag, input logic [7:0] st,
                            input int n, input bit spacing);
    checkOutput({tag, "_complete"}, 32'(cap_ok), 32'd1);
    checkOutput({tag, "_bits"}, 32'(cap_bits), 32'(expBits(st, n)));
    checkOutput({tag, "_active_len"}, 32'(cap_act), 32'(ACTIVE_LEN));
    checkOutput({tag, "_latch_len"}, 32'(cap_latch), 32'(CLK_DIV));
    checkOutput({tag, "_sdata_stable"}, 32'(cap_glitch), 32'd0);
    if (spacing && last_load >= 0)
      checkOutput({tag, "_load_spacing"}, 32'(cap_load - last_load), 32'(FRAME_CYCLES));
    last_load = cap_load;
  endtask

  initial begin
    // Reset values.
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0);
    last_load = -1;
    repeat (3) @(negedge clk);
    checkOutput("reset_active", 32'(led_active), 32'd0);
    checkOutput("reset_sclk",   32'(led_sclk),   32'd0);
    checkOutput("reset_sdata",  32'(led_sdata),  32'd0);
    checkOutput("reset_latch",  32'(led_latch),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_no_run", 32'(led_active), 32'd0);

    // First frame: LED3 on, LED2 off, LED1 on, LED0 off.
    nf = 0;
    cur_state = 8'b01_00_01_00;
    applyStimulus(cur_state, 1'b1);
    captureFrame(1'b0, 8'h00, 1'b0);
    checkFrame("first", cur_state, nf, 1'b1);
    checkOutput("first_sclk_latency", 32'(cap_first), 32'(1 + CLK_DIV));
    nf++;

    // Continuous run: all fast blink, then random codes each frame.
    for (int i = 0; i < 40; i++) begin
      cur_state = (i < 20) ? 8'hFF : 8'($urandom);
      led_state = cur_state;
      captureFrame(1'b0, 8'h00, 1'b0);
      checkFrame("run", cur_state, nf, 1'b1);
      nf++;
    end

    // led_state changes during SHIFT_HI of bit 2: old value now, new next.
    cur_state = 8'($urandom);
    new_state = ~cur_state;
    led_state = cur_state;
    captureFrame(1'b1, new_state, 1'b0);
    checkFrame("mid_old", cur_state, nf, 1'b1);
    nf++;
    captureFrame(1'b0, 8'h00, 1'b0);
    checkFrame("mid_new", new_state, nf, 1'b1);
    nf++;

    // led_run dropped during SHIFT_LO: the frame still completes.
    cur_state = 8'b01_01_11_10;
    led_state = cur_state;
    captureFrame(1'b0, 8'h00, 1'b1);
    checkFrame("drop", cur_state, nf, 1'b1);
    nf++;
`ifdef E1_LED_BLANK_EN
    captureFrame(1'b0, 8'h00, 1'b0);
    checkFrame("blank", 8'h00, 0, 1'b1);
`endif
    watchIdle(150);
    checkOutput("stop_idle_active", 32'(idle_act), 32'd0);
    checkOutput("stop_idle_sclk",   32'(idle_sclk), 32'd0);

    // Reset asserted during LATCH: outputs clear at once, counter restarts.
    applyStimulus(8'hFF, 1'b1);
    begin
      int guard;
      guard = 0;
      while (!led_latch && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("reach_latch", 32'(led_latch), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_active", 32'(led_active), 32'd0);
    checkOutput("async_rst_latch",  32'(led_latch),  32'd0);
    checkOutput("async_rst_sclk",   32'(led_sclk),   32'd0);
    checkOutput("async_rst_sdata",  32'(led_sdata),  32'd0);
    repeat (3) @(negedge clk);
    checkOutput("held_rst_active", 32'(led_active), 32'd0);
    nf = 0;
    last_load = -1;
    cur_state = 8'b11_10_01_00;
    led_state = cur_state;
    rst_n = 1'b1;
    captureFrame(1'b0, 8'h00, 1'b0);
    checkFrame("post_rst", cur_state, nf, 1'b1);
    nf++;

    // Blink counter wrap: all slow blink across more than 256 frames.
    cur_state = 8'hAA;
    led_state = cur_state;
    for (int i = 0; i < 257; i++) begin
      captureFrame(1'b0, 8'h00, 1'b0);
      checkFrame("wrap", cur_state, nf, 1'b1);
      nf++;
    end

    led_run = 1'b0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
